// File: rtl/wave_plotter.sv
// ---------------------------------------------------------------------------
// wave_plotter
//
// Waveform display engine. It takes 8-bit screen-row samples, triggers on a
// level crossing (or on a timeout), and captures one screen-width record into
// a ping-pong line buffer. At the same time it draws the record that is
// currently displayed as a 1-bit trace pixel from the live raster scan.
// Banks swap only at frame start (hcount == vcount == 0), so a frame is never
// drawn from two different records.
//
// Sample handshake: sample_data is consumed on every cycle where sample_valid
// is high. There is no back-pressure. Samples that arrive while a record waits
// for display (FULL), or in the swap cycle, are dropped.
//
// Ports
//   clk, reset       : pixel/system clock, synchronous active-high reset
//   sample_valid     : qualifies sample_data for one cycle
//   sample_data[7:0] : scaled sample (screen row, 0 = top)
//   trig_level[7:0]  : trigger threshold row
//   trig_rising      : 1 = trigger on increasing value, 0 = on decreasing
//   hcount, vcount   : current scan column / row
//   video_on         : active-video flag aligned with hcount/vcount
//   pixel_on         : trace pixel, 2 clocks after the scan inputs
//   armed            : high while waiting for a trigger
//   swap_pulse       : one-cycle pulse when the display bank changes
//   auto_trig        : displayed record was captured by timeout
// ---------------------------------------------------------------------------
module wave_plotter #(
    parameter int DEPTH    = 256,
    parameter int AW       = 8,
    parameter int X_OFFSET = 64,
    parameter int Y_OFFSET = 112,
    parameter int TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic [7:0] sample_data,
    input  logic [7:0] trig_level,
    input  logic       trig_rising,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       video_on,
    output logic       pixel_on,
    output logic       armed,
    output logic       swap_pulse,
    output logic       auto_trig
);

    localparam int TW = $clog2(TIMEOUT);

    // Window bounds, widened by one bit so the upper bound cannot wrap.
    localparam logic [10:0] X_LO = 11'(X_OFFSET);
    localparam logic [10:0] X_HI = 11'(X_OFFSET + DEPTH);
    localparam logic [10:0] Y_LO = 11'(Y_OFFSET);
    localparam logic [10:0] Y_HI = 11'(Y_OFFSET + 256);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [TW-1:0] tcount;
    logic          disp_bank;   // write bank is always ~disp_bank
    logic [7:0]    prev;
    logic          prev_valid;
    logic          auto_pend;

    // ------------------------------------------------------------------
    // Trigger / swap decode
    // ------------------------------------------------------------------
    logic swap_now;
    logic trig_hit;
    logic tmo_hit;

    always_comb begin
        swap_now = (state == FULL) && (hcount == 10'd0) && (vcount == 10'd0);
        trig_hit = 1'b0;
        if (prev_valid) begin
            if (trig_rising)
                trig_hit = (prev < trig_level) && (sample_data >= trig_level);
            else
                trig_hit = (prev > trig_level) && (sample_data <= trig_level);
        end
        tmo_hit = (tcount == TW'(TIMEOUT - 1));
    end

    // ------------------------------------------------------------------
    // Capture write port
    // ------------------------------------------------------------------
    logic          mem_we;
    logic [AW:0]   mem_waddr;
    logic [7:0]    mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = {~disp_bank, cnt};
        mem_wdata = sample_data;
        if (!reset && !swap_now && sample_valid) begin
            if (state == ARMED && (trig_hit || tmo_hit)) begin
                mem_we    = 1'b1;
                mem_waddr = {~disp_bank, {AW{1'b0}}};
            end else if (state == CAPTURE) begin
                mem_we    = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM (swap has priority; it is checked every cycle)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARMED;
            cnt        <= '0;
            tcount     <= '0;
            disp_bank  <= 1'b0;
            prev       <= '0;
            prev_valid <= 1'b0;
            auto_pend  <= 1'b0;
            armed      <= 1'b0;
            swap_pulse <= 1'b0;
            auto_trig  <= 1'b0;
        end else begin
            swap_pulse <= 1'b0;
            armed      <= (state == ARMED);
            if (swap_now) begin
                disp_bank  <= ~disp_bank;
                auto_trig  <= auto_pend;
                swap_pulse <= 1'b1;
                state      <= ARMED;
                tcount     <= '0;
                prev_valid <= 1'b0;
                armed      <= 1'b1;
            end else if (sample_valid) begin
                case (state)
                    ARMED: begin
                        if (trig_hit || tmo_hit) begin
                            // A real crossing on the timeout sample wins.
                            auto_pend  <= ~trig_hit;
                            cnt        <= AW'(1);
                            prev_valid <= 1'b0;
                            state      <= CAPTURE;
                            armed      <= 1'b0;
                        end else begin
                            prev       <= sample_data;
                            prev_valid <= 1'b1;
                            tcount     <= tcount + 1'b1;
                        end
                    end
                    CAPTURE: begin
                        cnt <= cnt + 1'b1;   // wraps to 0 after DEPTH-1
                        if (cnt == AW'(DEPTH - 1))
                            state <= FULL;
                    end
                    default: ;               // FULL: samples dropped
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffer: one write port, one synchronous read port
    // ------------------------------------------------------------------
    logic [7:0]    mem [0:2*DEPTH-1];
    logic [7:0]    rd_data;
    logic [AW-1:0] x_idx;
    logic [AW:0]   mem_raddr;

    always_comb begin
        x_idx     = AW'(hcount - 10'(X_OFFSET));
        mem_raddr = {disp_bank, x_idx};
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
        rd_data <= mem[mem_raddr];
    end

    // ------------------------------------------------------------------
    // Display pipeline
    // ------------------------------------------------------------------
    logic       s1_von;
    logic       s1_win;
    logic [7:0] s1_y;
    logic       s1_xzero;
    logic [7:0] last_q;
    logic       in_win;
    logic [7:0] last_sel;
    logic [7:0] lo;
    logic [7:0] hi;

    always_comb begin
        in_win = ({1'b0, hcount} >= X_LO) && ({1'b0, hcount} < X_HI) &&
                 ({1'b0, vcount} >= Y_LO) && ({1'b0, vcount} < Y_HI);
        // Column 0 has no left neighbour; draw only its own row.
        last_sel = s1_xzero ? rd_data : last_q;
        lo       = (last_sel < rd_data) ? last_sel : rd_data;
        hi       = (last_sel < rd_data) ? rd_data  : last_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_von   <= 1'b0;
            s1_win   <= 1'b0;
            s1_y     <= '0;
            s1_xzero <= 1'b0;
            last_q   <= '0;
            pixel_on <= 1'b0;
        end else begin
            s1_von   <= video_on;
            s1_win   <= in_win;
            s1_y     <= 8'(vcount - 10'(Y_OFFSET));
            s1_xzero <= (hcount == 10'(X_OFFSET));
            last_q   <= rd_data;
            pixel_on <= s1_von && s1_win && (s1_y >= lo) && (s1_y <= hi);
        end
    end

endmodule
